// File: rtl/alu_pkg.sv
// ALU function encodings shared by the decoder and the multiply/divide sequencer,
// plus the MULTU/DIVU selector type.
package alu_pkg;

  localparam logic [4:0] ALU_ADDU = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_OR   = 5'b00010;
  localparam logic [4:0] ALU_SUBU = 5'b00011;
  localparam logic [4:0] ALU_SLT  = 5'b00100;
  localparam logic [4:0] ALU_SLTU = 5'b00101;
  localparam logic [4:0] ALU_SLL  = 5'b00110;
  localparam logic [4:0] ALU_SLLV = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01000;
  localparam logic [4:0] ALU_SRLV = 5'b01001;
  localparam logic [4:0] ALU_SRA  = 5'b01010;
  localparam logic [4:0] ALU_SRAV = 5'b01011;

  typedef enum logic {
    MULTU = 1'b0,
    DIVU  = 1'b1
  } muldiv_op_t;

endpackage

// File: rtl/muldiv_seq.sv
// MULTU/DIVU sequencer borrowing the core ALU: shift-add multiply and restoring
// divide, one bit per two cycles, fixed 64-cycle latency; owns HI/LO.
module muldiv_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [4:0]  alu_funct,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shift,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MUL_ADD   = 3'd1;
  localparam logic [2:0] S_MUL_CARRY = 3'd2;
  localparam logic [2:0] S_DIV_CMP   = 3'd3;
  localparam logic [2:0] S_DIV_SUB   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] whi_q, whi_d;
  logic [31:0] wlo_q, wlo_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] sum_r_q, sum_r_d;
  logic        lt_r_q, lt_r_d;
  logic        ovf_r_q, ovf_r_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] addend;
  logic [31:0] rem_shift;
  logic        unused_alu_zero;

  assign addend          = wlo_q[0] ? opnd_q : 32'd0;
  assign rem_shift       = {whi_q[30:0], wlo_q[31]};
  assign unused_alu_zero = alu_zero;

  // ALU drive depends only on registered state, so the external ALU path never loops.
  always_comb begin
    alu_funct = ALU_ADDU;
    alu_a     = 32'd0;
    alu_b     = 32'd0;
    case (state_q)
      S_MUL_ADD:   begin alu_funct = ALU_ADDU; alu_a = whi_q;     alu_b = addend; end
      S_MUL_CARRY: begin alu_funct = ALU_SLTU; alu_a = sum_r_q;   alu_b = addend; end
      S_DIV_CMP:   begin alu_funct = ALU_SLTU; alu_a = rem_shift; alu_b = opnd_q; end
      S_DIV_SUB:   begin alu_funct = ALU_SUBU; alu_a = whi_q;     alu_b = opnd_q; end
      default:     ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    whi_d   = whi_q;
    wlo_d   = wlo_q;
    opnd_d  = opnd_q;
    sum_r_d = sum_r_q;
    lt_r_d  = lt_r_q;
    ovf_r_d = ovf_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d = 5'd0;
          whi_d = 32'd0;
          if (muldiv_op_t'(op) == DIVU) begin
            wlo_d   = a;
            opnd_d  = b;
            state_d = S_DIV_CMP;
          end else begin
            wlo_d   = b;
            opnd_d  = a;
            state_d = S_MUL_ADD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_ADD: begin
        sum_r_d = alu_result;
        state_d = S_MUL_CARRY;
      end
      S_MUL_CARRY: begin
        // SLTU(sum, addend) recovers the carry-out of the previous add.
        whi_d   = {alu_result[0], sum_r_q[31:1]};
        wlo_d   = {sum_r_q[0], wlo_q[31:1]};
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? S_DONE : S_MUL_ADD;
      end
      S_DIV_CMP: begin
        lt_r_d  = alu_result[0];
        ovf_r_d = whi_q[31];
        whi_d   = rem_shift;
        wlo_d   = {wlo_q[30:0], 1'b0};
        state_d = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        // A bit shifted out of whi means the true remainder exceeds any divisor.
        if (ovf_r_q || !lt_r_q) begin
          whi_d    = alu_result;
          wlo_d[0] = 1'b1;
        end
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? S_DONE : S_DIV_CMP;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE) begin
      hi_d = whi_d;
      lo_d = wlo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      whi_q   <= 32'd0;
      wlo_q   <= 32'd0;
      opnd_q  <= 32'd0;
      sum_r_q <= 32'd0;
      lt_r_q  <= 1'b0;
      ovf_r_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      whi_q   <= whi_d;
      wlo_q   <= wlo_d;
      opnd_q  <= opnd_d;
      sum_r_q <= sum_r_d;
      lt_r_q  <= lt_r_d;
      ovf_r_q <= ovf_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign alu_shift = 5'd0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: external ALU model, cycle-level result/timing model, and
// directed vectors with literal expected HI/LO values.
module tb_muldiv_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [4:0]  alu_funct, alu_shift;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b), .alu_shift(alu_shift),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Core ALU stand-in
  always_comb begin
    case (alu_funct)
      ALU_ADDU: alu_result = alu_a + alu_b;
      ALU_SUBU: alu_result = alu_a - alu_b;
      ALU_SLTU: alu_result = {31'd0, (alu_a < alu_b)};
      default:  alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Reference: an accepted op yields its arithmetic result exactly 64 edges later.
  bit          model_valid = 1'b0;
  int          rem = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic        m_done = 1'b0;
  logic [63:0] prod;

  always @(posedge clk) begin
    if (reset) begin
      model_valid = 1'b1;
      rem = 0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (start) begin
        if (op == 1'b0) begin
          prod = {32'd0, a} * {32'd0, b};
          p_hi = prod[63:32]; p_lo = prod[31:0];
        end else if (b == 32'd0) begin
          p_hi = a; p_lo = 32'hFFFF_FFFF;
        end else begin
          p_hi = a % b; p_lo = a / b;
        end
        rem = 64;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("busy", busy, rem > 0);
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("alu_shift", alu_shift, 0);
      if (rem == 0) chk("alu_idle", {alu_funct, alu_a, alu_b}, 0);
    end
  end

  task automatic drive_start(input logic o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int k0);
    int k;
    k = k0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, k, 65);
  endtask

  logic        v_op [7];
  logic [31:0] v_a [7], v_b [7], v_hi [7], v_lo [7];

  initial begin
    v_op[0] = 1'b0; v_a[0] = 32'd7;          v_b[0] = 32'd6;          v_hi[0] = 32'd0;          v_lo[0] = 32'd42;
    v_op[1] = 1'b0; v_a[1] = 32'hFFFF_FFFF;  v_b[1] = 32'hFFFF_FFFF;  v_hi[1] = 32'hFFFF_FFFE;  v_lo[1] = 32'h0000_0001;
    v_op[2] = 1'b0; v_a[2] = 32'h8000_0000;  v_b[2] = 32'd2;          v_hi[2] = 32'd1;          v_lo[2] = 32'd0;
    v_op[3] = 1'b1; v_a[3] = 32'd100;        v_b[3] = 32'd7;          v_hi[3] = 32'd2;          v_lo[3] = 32'd14;
    v_op[4] = 1'b1; v_a[4] = 32'h8000_0000;  v_b[4] = 32'd3;          v_hi[4] = 32'd2;          v_lo[4] = 32'h2AAA_AAAA;
    v_op[5] = 1'b1; v_a[5] = 32'hFFFF_FFFF;  v_b[5] = 32'h8000_0001;  v_hi[5] = 32'h7FFF_FFFE;  v_lo[5] = 32'd1;
    v_op[6] = 1'b1; v_a[6] = 32'h1234_5678;  v_b[6] = 32'd0;          v_hi[6] = 32'h1234_5678;  v_lo[6] = 32'hFFFF_FFFF;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    for (int i = 0; i < 7; i++) begin
      drive_start(v_op[i], v_a[i], v_b[i]);
      if (i == 0) begin
        chk("first_busy", busy, 1'b1);
        chk("first_hold_hilo", {hi, lo}, 64'd0);
      end
      wait_done($sformatf("vec%0d", i), 1);
      chk($sformatf("vec%0d_hi", i), hi, v_hi[i]);
      chk($sformatf("vec%0d_lo", i), lo, v_lo[i]);
      @(negedge clk);
    end

    // start pulsed mid-operation must be ignored
    drive_start(1'b1, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 11);
    chk("ignore_hi", hi, 32'd2);
    chk("ignore_lo", lo, 32'd14);
    @(negedge clk);

    // reset mid-operation aborts and clears HI/LO
    drive_start(1'b0, 32'd9, 32'd9);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // start held in the DONE cycle is accepted with no bubble
    drive_start(1'b0, 32'd7, 32'd6);
    wait_done("b2b_first", 1);
    chk("b2b_first_lo", lo, 32'd42);
    drive_start(1'b1, 32'd100, 32'd7);
    chk("b2b_second_busy", busy, 1'b1);
    wait_done("b2b_second", 1);
    chk("b2b_second_hi", hi, 32'd2);
    chk("b2b_second_lo", lo, 32'd14);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
